// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap sequencer.
// Contents: sample/tap widths, delay-line depth, tap-select width, FSM encoding,
// and the packed tap-vector type passed between the shift register and the top.
package fir_pkg;

    localparam int unsigned DATA_W   = 3;
    localparam int unsigned NUM_TAP  = 10;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned LAST_SEL = NUM_TAP - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Element 0 is the newest sample.
    typedef logic [NUM_TAP-1:0][DATA_W-1:0] tap_vec_t;

endpackage

// File: rtl/fir_tap_shift.sv
// NUM_TAP x DATA_W delay line with shift-enable and synchronous clear.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   shift_en    shift in din as the newest sample
//   clr         synchronous clear of every tap, wins over shift_en
//   din         incoming sample
//   taps        all taps in parallel, taps[0] newest
module fir_tap_shift
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output tap_vec_t          taps
);

    // Delay-line register; older samples move toward higher indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (clr) begin
            taps <= '0;
        end else if (shift_en) begin
            taps <= {taps[NUM_TAP-2:0], din};
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: holds a 10-deep sample delay line and, after each accepted
// sample, walks the mux select 0..9 while strobing the downstream MAC.
// Optional feature macro: FIR_OVERRUN_FLAG_EN adds the sticky oOverrun output.
// Ports:
//   iClk, iRsn        clock, asynchronous active-low reset
//   iEnSample, iFirIn sample strobe and data (accepted only in IDLE)
//   iClr              synchronous clear of taps and FSM, highest priority
//   oTap_0..oTap_9    delay-line taps, oTap_0 newest
//   oInSel            tap select to the mux
//   oMacClr, oMacEn   accumulator clear / enable
//   oSumValid         one-cycle pulse after the last MAC cycle
//   oBusy             high while a scan or its DONE cycle is in progress
//   oOverrun          (FIR_OVERRUN_FLAG_EN) sticky dropped-sample flag
module fir_tap_sequencer
    import fir_pkg::*;
(
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iEnSample,
    input  logic [DATA_W-1:0] iFirIn,
    input  logic              iClr,
    output logic [DATA_W-1:0] oTap_0,
    output logic [DATA_W-1:0] oTap_1,
    output logic [DATA_W-1:0] oTap_2,
    output logic [DATA_W-1:0] oTap_3,
    output logic [DATA_W-1:0] oTap_4,
    output logic [DATA_W-1:0] oTap_5,
    output logic [DATA_W-1:0] oTap_6,
    output logic [DATA_W-1:0] oTap_7,
    output logic [DATA_W-1:0] oTap_8,
    output logic [DATA_W-1:0] oTap_9,
    output logic [SEL_W-1:0]  oInSel,
    output logic              oMacClr,
    output logic              oMacEn,
    output logic              oSumValid,
    output logic              oBusy
`ifdef FIR_OVERRUN_FLAG_EN
    ,
    output logic              oOverrun
`endif
);

    fsm_state_t       state, state_d;
    logic [SEL_W-1:0] cnt, cnt_d;
    logic [SEL_W-1:0] in_sel_d;
    logic             mac_clr_d, mac_en_d, sum_valid_d, busy_d;
    logic             accept;
    tap_vec_t         taps;

    // Samples are only taken in IDLE; the shifter itself gives iClr priority.
    assign accept = (state == IDLE) && iEnSample;

    fir_tap_shift u_shift (
        .clk      (iClk),
        .rst_n    (iRsn),
        .shift_en (accept),
        .clr      (iClr),
        .din      (iFirIn),
        .taps     (taps)
    );

    assign oTap_0 = taps[0];
    assign oTap_1 = taps[1];
    assign oTap_2 = taps[2];
    assign oTap_3 = taps[3];
    assign oTap_4 = taps[4];
    assign oTap_5 = taps[5];
    assign oTap_6 = taps[6];
    assign oTap_7 = taps[7];
    assign oTap_8 = taps[8];
    assign oTap_9 = taps[9];

    // Next state / counter, then strobes decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        in_sel_d    = '0;
        mac_clr_d   = 1'b0;
        mac_en_d    = 1'b0;
        sum_valid_d = 1'b0;
        busy_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (iEnSample) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (cnt == SEL_W'(LAST_SEL)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + SEL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (iClr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        busy_d      = (state_d != IDLE);
        mac_en_d    = (state_d == SCAN);
        in_sel_d    = (state_d == SCAN) ? cnt_d : '0;
        mac_clr_d   = (state_d == SCAN) && (cnt_d == '0);
        sum_valid_d = (state_d == DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state     <= IDLE;
            cnt       <= '0;
            oInSel    <= '0;
            oMacClr   <= 1'b0;
            oMacEn    <= 1'b0;
            oSumValid <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            oInSel    <= in_sel_d;
            oMacClr   <= mac_clr_d;
            oMacEn    <= mac_en_d;
            oSumValid <= sum_valid_d;
            oBusy     <= busy_d;
        end
    end

`ifdef FIR_OVERRUN_FLAG_EN
    // Sticky flag for samples offered while busy; iClr wins over a new drop.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            oOverrun <= 1'b0;
        end else if (iClr) begin
            oOverrun <= 1'b0;
        end else if (iEnSample && (state != IDLE)) begin
            oOverrun <= 1'b1;
        end
    end
`endif

endmodule
